// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-stage SRAM controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_ADDR_BASE   = 1024;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 1;
    localparam int unsigned DEFAULT_SRAM_AW     = 18;

    // Word offset of a byte address relative to the SRAM window base.
    function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_read_buffer.sv
// Single-entry read buffer: one tagged 32-bit word, filled by completed
// loads and kept coherent by write-through on matching stores.
module mem_read_buffer #(
    parameter int unsigned IW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] lookup_idx,
    output logic          hit,
    output logic [31:0]   data,
    input  logic          fill_en,
    input  logic [IW-1:0] fill_idx,
    input  logic [31:0]   fill_data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wr_data
);

    logic          valid;
    logic [IW-1:0] tag;

    assign hit = valid && (tag == lookup_idx);

    // Fill on load completion; a matching store only refreshes the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_idx;
            data  <= fill_data;
        end else if (wr_en && valid && (tag == wr_idx)) begin
            data  <= wr_data;
        end
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage access controller: splits one 32-bit load/store into two
// 16-bit SRAM accesses with WAIT_CYCLES extra hold cycles each, and stalls
// the pipeline through `ready` while an access is in flight.
// Optional macro MEM_READ_BUFFER_EN adds a single-entry read buffer.
//
// state | meaning
// IDLE  | no access; ready=1 unless a new request is being accepted
// LO    | low half-word access at {wordIdx,0}
// HI    | high half-word access at {wordIdx,1}
// DONE  | access complete, ready=1 for one cycle, SRAM idle
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memReadEn,
    input  logic               memWriteEn,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] sramAddr,
    output logic [15:0]        sramDqOut,
    input  logic [15:0]        sramDqIn,
    output logic               sramDqOe,
    output logic               sramWeN
);

    localparam int unsigned IW        = SRAM_AW - 1;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

    state_t        state, state_n;
    logic [3:0]    cnt;
    logic          op_write;
    logic [IW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [IW-1:0] req_idx;
    logic          req, start, lo_last, hi_last, buf_go;
    logic          buf_hit;
    logic [31:0]   buf_data;

    assign req     = memReadEn | memWriteEn;
    assign req_idx = IW'(word_offset(address, 32'(ADDR_BASE)));

`ifdef MEM_READ_BUFFER_EN
    mem_read_buffer #(.IW(IW)) u_read_buffer (
        .clk        (clk),
        .rst        (rst),
        .lookup_idx (req_idx),
        .hit        (buf_hit),
        .data       (buf_data),
        .fill_en    (hi_last & ~op_write),
        .fill_idx   (idx_q),
        .fill_data  ({sramDqIn, readData[15:0]}),
        .wr_en      (hi_last & op_write),
        .wr_idx     (idx_q),
        .wr_data    (wdata_q)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state and stall decode; stores win when both request lines are high.
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        start   = 1'b0;
        lo_last = 1'b0;
        hi_last = 1'b0;
        buf_go  = 1'b0;
        case (state)
            IDLE: begin
                if (!req) begin
                    ready = 1'b1;
                end else if (memReadEn && !memWriteEn && buf_hit) begin
                    buf_go  = 1'b1;
                    state_n = DONE;
                end else begin
                    start   = 1'b1;
                    state_n = LO;
                end
            end
            LO: begin
                if (cnt == WAIT_LAST) begin
                    lo_last = 1'b1;
                    state_n = HI;
                end
            end
            HI: begin
                if (cnt == WAIT_LAST) begin
                    hi_last = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latch, wait counter, SRAM pins and load data; SRAM pins change
    // on the same edge as the state so they line up with LO/HI exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            op_write  <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            readData  <= '0;
            sramAddr  <= '0;
            sramDqOut <= '0;
            sramDqOe  <= 1'b0;
            sramWeN   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (buf_go) readData <= buf_data;
                    if (start) begin
                        op_write <= memWriteEn;
                        idx_q    <= req_idx;
                        wdata_q  <= writeData;
                        sramAddr <= {req_idx, 1'b0};
                        sramWeN  <= ~memWriteEn;
                        sramDqOe <= memWriteEn;
                        if (memWriteEn) sramDqOut <= writeData[15:0];
                    end
                end
                LO: begin
                    if (lo_last) begin
                        cnt      <= '0;
                        sramAddr <= {idx_q, 1'b1};
                        if (op_write) sramDqOut <= wdata_q[31:16];
                        else          readData[15:0] <= sramDqIn;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HI: begin
                    if (hi_last) begin
                        cnt      <= '0;
                        sramWeN  <= 1'b1;
                        sramDqOe <= 1'b0;
                        if (!op_write) readData[31:16] <= sramDqIn;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl with a behavioural SRAM.
// Transactions come from a vector table plus hand-written reset and
// read-buffer sequences; results are matched through scoreboard queues.
module tb_mem_stage_sram_ctrl;

    localparam int unsigned TB_WAIT = 1;
    localparam int unsigned LAT     = 2 * (TB_WAIT + 1) + 2;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        memReadEn, memWriteEn;
    logic [31:0] address, writeData, readData;
    logic        ready;
    logic [17:0] sramAddr;
    logic [15:0] sramDqOut, sramDqIn;
    logic        sramDqOe, sramWeN;

    logic [15:0] sram [0:255];
    exp_t        sb_q[$];
    wr_t         wr_q[$];
    wr_t         wmon;
    logic        mon_en = 1'b1;
    int          tests = 0;
    int          fails = 0;

    mem_stage_sram_ctrl #(.ADDR_BASE(1024), .WAIT_CYCLES(TB_WAIT), .SRAM_AW(18)) dut (
        .clk        (clk),
        .rst        (rst),
        .memReadEn  (memReadEn),
        .memWriteEn (memWriteEn),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData),
        .ready      (ready),
        .sramAddr   (sramAddr),
        .sramDqOut  (sramDqOut),
        .sramDqIn   (sramDqIn),
        .sramDqOe   (sramDqOe),
        .sramWeN    (sramWeN)
    );

    always #5 clk = ~clk;

    assign sramDqIn = sram[sramAddr[7:0]];

    // Behavioural SRAM write port.
    always @(posedge clk) begin
        if (!sramWeN && sramDqOe) sram[sramAddr[7:0]] <= sramDqOut;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] word_idx(input logic [31:0] a);
        logic [31:0] d;
        d = (a - 32'd1024) >> 2;
        return d[16:0];
    endfunction

    // Every SRAM write cycle must match the next expected write.
    always @(negedge clk) begin
        if (mon_en && !rst && !sramWeN) begin
            if (wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sram_wr_unexpected actual_addr=%h required=no_write", sramAddr);
            end else begin
                wmon = wr_q.pop_front();
                check("sram_wr_addr", 32'(sramAddr), 32'(wmon.addr));
                check("sram_wr_data", 32'(sramDqOut), 32'(wmon.data));
                check("sram_wr_oe", 32'(sramDqOe), 32'd1);
            end
        end
    end

    task automatic do_txn(input string name, input vec_t v);
        exp_t        e;
        wr_t         w;
        logic [16:0] idx;
        int          cyc;
        @(posedge clk);
        #1;
        memWriteEn = v.wr;
        memReadEn  = v.rd;
        address    = v.addr;
        writeData  = v.wdata;
        e.rdata = v.exp_rdata;
        e.lat   = v.exp_lat;
        sb_q.push_back(e);
        if (v.wr) begin
            idx = word_idx(v.addr);
            for (int h = 0; h < 2; h++) begin
                for (int c = 0; c <= int'(TB_WAIT); c++) begin
                    w.addr = {idx, h[0]};
                    w.data = (h == 0) ? v.wdata[15:0] : v.wdata[31:16];
                    wr_q.push_back(w);
                end
            end
        end
        cyc = 1;
        @(negedge clk);
        while (!ready && cyc < 40) begin
            if (cyc == 2) begin
                address   = $urandom;
                writeData = $urandom;
            end
            cyc++;
            @(negedge clk);
        end
        if (!ready) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout actual=no_ready required=ready_within_40", name);
        end
        memWriteEn = 1'b0;
        memReadEn  = 1'b0;
        e = sb_q.pop_front();
        check({name, "_rdata"}, readData, e.rdata);
        check({name, "_latency"}, 32'(cyc), 32'(e.lat));
    endtask

    vec_t vecs[8];
    vec_t hv;
    logic [17:0] prev_addr;
    int   guard;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h00000000, LAT};
        vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'hDEADBEEF, LAT};
        vecs[2] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 32'hDEADBEEF, LAT};
        vecs[3] = '{1'b0, 1'b1, 32'd1032, 32'h0,        32'hCAFEF00D, LAT};
        vecs[4] = '{1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 32'hCAFEF00D, LAT};
        vecs[5] = '{1'b0, 1'b1, 32'd1020, 32'h0,        32'hA5A55A5A, LAT};
        vecs[6] = '{1'b1, 1'b0, 32'd1024, 32'h00010002, 32'hA5A55A5A, LAT};
        vecs[7] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'h00010002, LAT};

        for (int i = 0; i < 256; i++) sram[i] = 16'h0;
        rst = 1'b1;
        memReadEn = 1'b0;
        memWriteEn = 1'b0;
        address = 32'h0;
        writeData = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_readData", readData, 32'h0);
        check("rst_sramAddr", 32'(sramAddr), 32'h0);
        check("rst_sramDqOut", 32'(sramDqOut), 32'h0);
        check("rst_sramDqOe", 32'(sramDqOe), 32'h0);
        check("rst_sramWeN", 32'(sramWeN), 32'h1);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'h1);
            check("idle_sramWeN", 32'(sramWeN), 32'h1);
            check("idle_sramDqOe", 32'(sramDqOe), 32'h0);
        end

        for (int i = 0; i < 8; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of the high half of a store.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        memWriteEn = 1'b1;
        address    = 32'd1040;
        writeData  = 32'h11112222;
        guard = 0;
        @(negedge clk);
        while ((sramWeN || !sramAddr[0]) && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        check("rstmid_reached_hi", 32'(sramAddr), {14'h0, word_idx(32'd1040), 1'b1});
        memWriteEn = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_sramWeN", 32'(sramWeN), 32'h1);
        check("rstmid_sramDqOe", 32'(sramDqOe), 32'h0);
        check("rstmid_readData", readData, 32'h0);
        check("rstmid_sramAddr", 32'(sramAddr), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_ready_after", 32'(ready), 32'h1);
        check("rstmid_weN_after", 32'(sramWeN), 32'h1);
        mon_en = 1'b1;

        hv = '{1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, LAT};
        do_txn("reload", hv);
`ifdef MEM_READ_BUFFER_EN
        prev_addr = sramAddr;
        hv = '{1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, 2};
        do_txn("buf_hit", hv);
        check("buf_hit_no_sram", 32'(sramAddr), 32'(prev_addr));
        hv = '{1'b1, 1'b0, 32'd1028, 32'h12345678, 32'hDEADBEEF, LAT};
        do_txn("buf_wt_store", hv);
        hv = '{1'b0, 1'b1, 32'd1028, 32'h0, 32'h12345678, 2};
        do_txn("buf_wt_load", hv);
`else
        prev_addr = sramAddr;
        hv = '{1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, LAT};
        do_txn("reload2", hv);
        check("reload2_addr", 32'(sramAddr), 32'(prev_addr));
`endif

        repeat (2) @(negedge clk);
        check("wr_queue_drained", 32'(wr_q.size()), 32'h0);
        check("sb_queue_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
Memory-stage access controller of the ARM 5-stage pipeline. It sits between EX/MEM outputs and the MEM/WB register. It converts one 32-bit load/store into two 16-bit accesses to an external SRAM, with configurable wait states. It drives the global `ready` that freezes all pipeline registers while an access is in flight.

Parameters:
- ADDR_BASE, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 1: extra cycles each half-word access holds address/control (0..15).
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- memReadEn  in  1  load request from EX/MEM
- memWriteEn  in  1  store request from EX/MEM
- address  in  32  byte address (ALU result)
- writeData  in  32  store data (Rm value)
- readData  out  32  loaded word, valid when ready=1 after a load
- ready  out  1  pipeline advance enable
- sramAddr  out  SRAM_AW  half-word address
- sramDqOut  out  16  write data to SRAM
- sramDqIn  in  16  read data from SRAM
- sramDqOe  out  1  1 = controller drives the DQ bus
- sramWeN  out  1  active-low write enable

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: state=IDLE, readData=0, sramAddr=0, sramDqOut=0, sramDqOe=0, sramWeN=1, wait counter=0.
- Word index: wordIdx = (address - ADDR_BASE) >> 2, truncated to SRAM_AW-1 bits (modular, no range check).
- Half-word addresses: low half = {wordIdx,0}; high half = {wordIdx,1}.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - No request: ready=1, stay in IDLE.
  - Request present: ready=0, latch op/address/writeData, go to LO with counter=0.
  - memWriteEn has priority when both request lines are high.
- LO: drive low half-word address.
  - Store: sramWeN=0, sramDqOe=1, sramDqOut=writeData[15:0].
  - Counter increments each cycle.
  - When counter==WAIT_CYCLES: a load captures sramDqIn into readData[15:0]; clear counter, go to HI.
- HI: same as LO for the high half (writeData[31:16] / readData[31:16]), then go to DONE.
- DONE: ready=1 for exactly one cycle, SRAM idle (sramWeN=1, sramDqOe=0), then go to IDLE.
- Latency: a request seen in IDLE gives ready=1 on cycle 2*(WAIT_CYCLES+1)+2 after it was first seen (6 cycles for WAIT_CYCLES=1). ready=0 on all earlier cycles.
- A request still present in IDLE on the cycle after DONE is a new instruction and starts a new access.
- Inputs are latched in IDLE; changes during LO/HI are ignored.
- readData holds its last loaded value through stores and idle cycles.
- Outside LO/HI: sramWeN=1 and sramDqOe=0. sramAddr holds its last value.
- Reset mid-access aborts immediately to IDLE with reset values. There is no partial-write recovery.

Optional Feature:
MEM_READ_BUFFER_EN
- With the macro: a single-entry read buffer (valid, wordIdx tag, 32-bit data) is added.
  - Load in IDLE with valid and matching tag: go straight to DONE, readData = buffered data. ready=1 on the next cycle, with no SRAM activity.
  - A load completing from SRAM fills the buffer.
  - A store to a matching tag updates the buffer data (write-through).
  - Reset clears valid.
- Without the macro: every load goes to SRAM. No buffer flops exist.

Decomposition:
- Shared package mem_pkg: state enum (IDLE/LO/HI/DONE), default ADDR_BASE, SRAM_AW.
- Natural sub-module: mem_read_buffer (tag compare, fill, write-through). It is instantiated only under MEM_READ_BUFFER_EN.

Test Plan:
1. Idle, no requests -> ready=1 every cycle, sramWeN=1, sramDqOe=0.
2. Store 0xDEADBEEF to address 1028, WAIT_CYCLES=1:
   - SRAM sees addr 2 with 0xBEEF, then addr 3 with 0xDEAD, each with sramWeN=0 for 2 cycles.
   - ready=1 on cycle 6.
3. Load from 1028 after test 2 -> readData=0xDEADBEEF with ready=1 on cycle 6; ready=0 on cycles 1-5.
4. Both memReadEn and memWriteEn high -> a store is performed; readData unchanged.
5. Assert rst during HI of a store -> same-cycle sramWeN=1, readData=0, state IDLE; ready=1 next cycle with no request.
6. With MEM_READ_BUFFER_EN:
   - Repeat the load of 1028 -> ready=1 on cycle 2, no SRAM access.
   - Store 0x12345678 to 1028, then load -> 0x12345678 returned from the buffer.
